ultra_sonic_filter: RTL and testbench
=====================================

ULTRA_SONIC_FILTER -- requirements
Module: ultra_sonic_filter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 32'd1_200_000: largest accepted raw echo count.
REQ-002 SHALL have parameter NEAR_THRESH, default 32'd29_000: alarm assert threshold (average count).
REQ-003 SHALL have parameter FAR_THRESH, default 32'd35_000: alarm release threshold; FAR_THRESH > NEAR_THRESH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 23'd6_000_000: cycles without an accepted sample before timeout.
REQ-005 SHALL have port clk, input, 1, 50 MHz clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port sample_data, input, 32, raw echo count from the ultrasonic stage.
REQ-008 SHALL have port sample_valid, input, 1, pulse; sample_data is valid on the cycle after it.
REQ-009 SHALL have port clear, input, 1, synchronous clear of sticky flags and reject counter.
REQ-010 SHALL have port avg_data, output, 32, 4-sample moving average.
REQ-011 SHALL have port avg_valid, output, 1, one-cycle pulse when avg_data updates.
REQ-012 SHALL have port near, output, 1, proximity alarm with hysteresis.
REQ-013 SHALL have port timeout, output, 1, no accepted sample within TIMEOUT_CYCLES.
REQ-014 SHALL have port overrun, output, 1, sticky: sample_valid arrived while busy.
REQ-015 SHALL have port reject_count, output, 16, saturating count of out-of-range samples.

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURE, CHECK, OUTPUT.
REQ-017 SHALL move IDLE->CAPTURE when sample_valid=1, else remain IDLE.
REQ-018 SHALL in CAPTURE latch sample_data into sample_reg and move to CHECK.
REQ-019 SHALL in CHECK treat sample_reg==0 or sample_reg>MAX_COUNT as rejected: reject_count+1 (saturate at 16'hFFFF), buffer untouched, go IDLE.
REQ-020 SHALL in CHECK, for accepted samples, write sample_reg into a 4-entry ring buffer at wr_ptr, update sum = sum + sample_reg - oldest entry, advance wr_ptr mod 4, fill = min(fill+1,4), reload timeout counter, go OUTPUT.
REQ-021 SHALL keep sum at 34 bits; no overflow is possible since entries are <= MAX_COUNT.
REQ-022 SHALL in OUTPUT, if fill==4, set avg_data = sum[33:2] (truncate) and pulse avg_valid for that single cycle; if fill<4, produce no pulse and hold avg_data; always go IDLE.
REQ-023 SHALL give latency: sample_valid at cycle N -> avg_valid at cycle N+3.
REQ-024 SHALL treat sample_valid in any state other than IDLE as dropped and set overrun=1.
REQ-025 SHALL update near only on an avg_valid cycle: set when new avg_data < NEAR_THRESH; clear when new avg_data > FAR_THRESH; otherwise hold.
REQ-026 SHALL decrement a 23-bit timeout counter each cycle while nonzero; timeout=1 while counter==0; reload to TIMEOUT_CYCLES on every accepted sample.
REQ-027 SHALL on clear=1 zero overrun and reject_count that cycle; clear has priority over a simultaneous increment/set; buffer, sum, and FSM are unaffected.

Reset
REQ-028 SHALL on reset=1 asynchronously force state=IDLE, buffer entries, sum, fill, wr_ptr, sample_reg, avg_data=0, avg_valid=0, near=0, overrun=0, reject_count=0, timeout counter=TIMEOUT_CYCLES (timeout=0).
REQ-029 SHALL, on reset mid-operation, discard any in-flight sample with no avg_valid pulse.

Verification
REQ-030 Accepted samples 1000, 2000, 3000, 4000 -> no avg_valid for the first three; 4th gives avg_valid at N+3 with avg_data=2500.
REQ-031 Then sample 8000 -> avg_data=(2000+3000+4000+8000)>>2=4250; samples 0 and 1_300_000 -> reject_count=2, no avg_valid, avg_data stays 4250.
REQ-032 Four samples of 20_000 -> near=1; 30_000 x4 -> near stays 1; 40_000 x4 -> near=0.
REQ-033 sample_valid held high 2 cycles -> second dropped, overrun=1; clear pulse -> overrun=0, reject_count=0.
REQ-034 With TIMEOUT_CYCLES overridden to 100: no samples for 100 cycles after reset -> timeout=1; one accepted sample -> timeout=0 the next cycle.
REQ-035 reset asserted during CHECK -> all outputs zero immediately; next 4 samples of 500 -> avg_data=500 on the 4th only.

Source files
------------

// File: rtl/ultra_sonic_filter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ultra_sonic_filter
// Description : Range-checks raw ultrasonic echo counts, keeps a 4-sample
//               moving average, and derives a hysteretic proximity alarm,
//               a no-sample timeout, an overrun flag and a reject counter.
// Ports       : clk, reset (async, active-high)
//               sample_valid/sample_data  - raw echo input (data one cycle
//                                           after the valid pulse)
//               clear                     - clears overrun and reject_count
//               avg_data/avg_valid        - moving average and update pulse
//               near, timeout, overrun, reject_count - status outputs
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ultra_sonic_filter #(
    parameter logic [31:0] MAX_COUNT      = 32'd1_200_000,
    parameter logic [31:0] NEAR_THRESH    = 32'd29_000,
    parameter logic [31:0] FAR_THRESH     = 32'd35_000,
    parameter logic [22:0] TIMEOUT_CYCLES = 23'd6_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sample_data,
    input  logic        sample_valid,
    input  logic        clear,
    output logic [31:0] avg_data,
    output logic        avg_valid,
    output logic        near,
    output logic        timeout,
    output logic        overrun,
    output logic [15:0] reject_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] sample_reg;
    logic [31:0] buffer [4];
    logic [1:0]  wr_ptr;
    logic [2:0]  fill;
    logic [33:0] sum;
    logic [22:0] timeout_cnt;

    logic        sample_ok;
    logic        accept;
    logic [33:0] sum_next;
    logic [2:0]  fill_next;

    assign sample_ok = (sample_reg != 32'd0) && (sample_reg <= MAX_COUNT);
    assign accept    = (state == CHECK) && sample_ok;
    // The slot being overwritten holds the oldest entry (zero until the ring
    // has filled), so the running sum never needs a full re-add.
    assign sum_next  = sum + {2'b00, sample_reg} - {2'b00, buffer[wr_ptr]};
    assign fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    assign timeout   = (timeout_cnt == 23'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_valid) state_next = CAPTURE;
            CAPTURE: state_next = CHECK;
            CHECK:   state_next = sample_ok ? OUTPUT : IDLE;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The average is registered on the CHECK->OUTPUT edge so that
    // avg_data/avg_valid are presented during the OUTPUT cycle (N+3).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_reg <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                buffer[i] <= 32'd0;
            end
            wr_ptr    <= 2'd0;
            fill      <= 3'd0;
            sum       <= 34'd0;
            avg_data  <= 32'd0;
            avg_valid <= 1'b0;
            near      <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (state == CAPTURE) begin
                sample_reg <= sample_data;
            end
            if (accept) begin
                buffer[wr_ptr] <= sample_reg;
                sum            <= sum_next;
                wr_ptr         <= wr_ptr + 2'd1;
                fill           <= fill_next;
                if (fill_next == 3'd4) begin
                    avg_data  <= sum_next[33:2];
                    avg_valid <= 1'b1;
                end
            end
            // Hysteresis: evaluated only against a freshly published average.
            if (avg_valid) begin
                if (avg_data < NEAR_THRESH) begin
                    near <= 1'b1;
                end else if (avg_data > FAR_THRESH) begin
                    near <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= TIMEOUT_CYCLES;
        end else if (accept) begin
            timeout_cnt <= TIMEOUT_CYCLES;
        end else if (timeout_cnt != 23'd0) begin
            timeout_cnt <= timeout_cnt - 23'd1;
        end
    end

    // Sticky status; clear wins over a same-cycle set or increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun      <= 1'b0;
            reject_count <= 16'd0;
        end else if (clear) begin
            overrun      <= 1'b0;
            reject_count <= 16'd0;
        end else begin
            if (sample_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if ((state == CHECK) && !sample_ok && (reject_count != 16'hFFFF)) begin
                reject_count <= reject_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultra_sonic_filter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ultra_sonic_filter
// Description : Scoreboard bench for ultra_sonic_filter. Stimulus tasks push
//               expected averages computed from a sample-history model; an
//               independent monitor checks every avg_valid pulse, its latency
//               and the resulting proximity alarm.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ultra_sonic_filter;

    localparam logic [31:0] MAX_C   = 32'd1_200_000;
    localparam longint      NEAR_T  = 29_000;
    localparam longint      FAR_T   = 35_000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        clear;
    logic [31:0] avg_data;
    logic        avg_valid;
    logic        near;
    logic        timeout;
    logic        overrun;
    logic [15:0] reject_count;

    ultra_sonic_filter #(
        .MAX_COUNT      (MAX_C),
        .NEAR_THRESH    (32'd29_000),
        .FAR_THRESH     (32'd35_000),
        .TIMEOUT_CYCLES (23'd100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .clear        (clear),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .near         (near),
        .timeout      (timeout),
        .overrun      (overrun),
        .reject_count (reject_count)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint avg;
        bit     near_exp;
        int     cyc_exp;
    } exp_t;

    exp_t   expq[$];
    longint hist[$];
    bit     model_near;
    int     model_rej;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        expq.delete();
        model_near = 1'b0;
        model_rej  = 0;
    endtask

    // Reference: average of the last four accepted samples, alarm hysteresis.
    task automatic model_sample(input longint v, input int issue);
        longint s;
        exp_t   e;
        if (v != 0 && v <= longint'(MAX_C)) begin
            hist.push_back(v);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4) begin
                s = 0;
                foreach (hist[i]) s += hist[i];
                e.avg = s / 4;
                if (e.avg < NEAR_T)      model_near = 1'b1;
                else if (e.avg > FAR_T)  model_near = 1'b0;
                e.near_exp = model_near;
                e.cyc_exp  = issue + 3;
                expq.push_back(e);
            end
        end else if (model_rej < 65535) begin
            model_rej++;
        end
    endtask

    // One-cycle valid pulse; returns once the FSM is back in IDLE.
    task automatic send(input logic [31:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = v;
        model_sample(longint'(v), cyc);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops on every avg_valid, then checks near one cycle later.
    initial begin
        exp_t e;
        bit   near_pending = 1'b0;
        bit   near_want    = 1'b0;
        forever begin
            @(negedge clk);
            if (near_pending) begin
                chk("near", near, near_want);
                near_pending = 1'b0;
            end
            if (avg_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_avg_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("avg_data", avg_data, e.avg);
                    chk("avg_latency", cyc, e.cyc_exp);
                    near_want    = e.near_exp;
                    near_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          r;

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 32'd0;
        clear        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_near", near, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_reject", reject_count, 0);
        reset = 1'b0;

        // Timeout boundary: 99 edges still counting, 100th reaches zero.
        repeat (99) @(negedge clk);
        chk("timeout_99", timeout, 0);
        @(negedge clk);
        chk("timeout_100", timeout, 1);

        send(32'd1000);
        chk("timeout_reload", timeout, 0);
        send(32'd2000);
        send(32'd3000);
        send(32'd4000);
        send(32'd8000);
        send(32'd0);
        send(32'd1_300_000);
        chk("reject_two", reject_count, 2);
        chk("avg_hold", avg_data, 4250);

        repeat (4) send(32'd20_000);
        chk("near_set", near, 1);
        repeat (4) send(32'd30_000);
        chk("near_hold", near, 1);
        repeat (4) send(32'd40_000);
        chk("near_clear", near, 0);

        // Valid held two cycles: second is dropped, first still processed.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 32'd5000;
        model_sample(64'd5000, cyc);
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("overrun_set", overrun, 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_rej = 0;
        chk("clear_overrun", overrun, 0);
        chk("clear_reject", reject_count, 0);

        // Clear coinciding with a rejected sample's CHECK cycle wins.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 32'd0;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_priority", reject_count, 0);

        // Reset while a sample sits in CHECK.
        send(32'd0);
        chk("reject_pre_reset", reject_count, 1);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 32'd500;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_avg_data", avg_data, 0);
        chk("mid_rst_avg_valid", avg_valid, 0);
        chk("mid_rst_near", near, 0);
        chk("mid_rst_reject", reject_count, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_timeout", timeout, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) send(32'd500);
        repeat (2) @(negedge clk);
        chk("avg_500", avg_data, 500);

        // Randomized traffic, including range boundaries.
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       v = 32'd0;
                1:       v = MAX_C + $urandom_range(1, 1000);
                2:       v = ($urandom_range(0, 1) == 0) ? MAX_C : 32'($urandom_range(1, 1_200_000));
                default: v = 32'($urandom_range(1, 60_000));
            endcase
            send(v);
            chk("rand_reject", reject_count, model_rej);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
